// File: rtl/cla_pkg.sv
// Shared constants and the per-stage pipeline record for the pipelined CLA adder/subtractor.
// Record fields are sized for the widest legal build; narrower builds leave the upper bits constant.
package cla_pkg;

   localparam int SLICE_W = 16;
   localparam int GROUP_W = 4;
   localparam int MAX_W   = 128;

   typedef struct packed {
      logic             valid;
      logic             carry;   // carry out of the slice most recently added
      logic             c_msb;   // carry into the top bit of that slice
      logic             sub;
      logic             sat;
      logic [MAX_W-1:0] psum;
      logic [MAX_W-1:0] a;
      logic [MAX_W-1:0] b;       // already inverted for subtraction
   } stage_t;

endpackage

// File: rtl/pipe_cla_addsub_if.sv
// Operand/result handshake bundle for pipe_cla_addsub.
// The sat signal exists only when ADDSUB_SAT_EN is defined.
interface pipe_cla_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
`ifdef ADDSUB_SAT_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
`ifdef ADDSUB_SAT_EN
      output sat,
`endif
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
`ifdef ADDSUB_SAT_EN
      input  sat,
`endif
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/cla_slice16.sv
// 16-bit combinational adder: four 4-bit lookahead groups joined by a second lookahead level.
module cla_slice16
   import cla_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout,
   output logic               c_msb_in
);
   localparam int NG = SLICE_W / GROUP_W;

   logic [SLICE_W-1:0] w_g;
   logic [SLICE_W-1:0] w_p;
   logic [SLICE_W-1:0] w_c;
   logic [NG-1:0]      w_gg;
   logic [NG-1:0]      w_gp;
   logic [NG:0]        w_gc;

   assign w_g = a & b;
   assign w_p = a ^ b;

   genvar gi;
   generate
      for (gi = 0; gi < NG; gi++) begin : g_grp
         localparam int L = gi * GROUP_W;
         assign w_gg[gi] = w_g[L+3] | (w_p[L+3] & w_g[L+2]) | (&w_p[L+3:L+2] & w_g[L+1])
                         | (&w_p[L+3:L+1] & w_g[L]);
         assign w_gp[gi] = &w_p[L+3:L];
         assign w_c[L]   = w_gc[gi];
         assign w_c[L+1] = w_g[L] | (w_p[L] & w_gc[gi]);
         assign w_c[L+2] = w_g[L+1] | (w_p[L+1] & w_g[L]) | (&w_p[L+1:L] & w_gc[gi]);
         assign w_c[L+3] = w_g[L+2] | (w_p[L+2] & w_g[L+1]) | (&w_p[L+2:L+1] & w_g[L])
                         | (&w_p[L+2:L] & w_gc[gi]);
      end
   endgenerate

   // Second level: group carries straight from cin, no chaining between groups.
   assign w_gc[0] = cin;
   assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
   assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & cin);
   assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0]) | (&w_gp[2:0] & cin);
   assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (&w_gp[3:2] & w_gg[1])
                  | (&w_gp[3:1] & w_gg[0]) | (&w_gp[3:0] & cin);

   assign s        = w_p ^ w_c;
   assign cout     = w_gc[NG];
   assign c_msb_in = w_c[SLICE_W-1];
endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract: one 16-bit CLA slice per stage, LAT = WIDTH/16 stages, valid/ready flow.
// Define ADDSUB_SAT_EN to add the per-beat signed saturation request (bus.sat).
module pipe_cla_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   pipe_cla_addsub_if.slave bus
);
   localparam int LAT = WIDTH / SLICE_W;

   stage_t                      r_stage [LAT];
   stage_t                      w_in    [LAT];
   stage_t                      w_out   [LAT];
   logic [LAT-1:0][SLICE_W-1:0] w_s;
   logic [LAT-1:0]              w_co;
   logic [LAT-1:0]              w_cm;
   logic [WIDTH-1:0]            w_b_eff;
   logic [WIDTH-1:0]            w_raw;
   logic [WIDTH-1:0]            w_sum;
   logic                        w_stall;
   logic                        w_ovf;

   // A stalled result freezes the whole pipe, so upstream can only move when the tail does.
   assign w_stall      = r_stage[LAT-1].valid & ~bus.out_ready;
   assign bus.in_ready = ~w_stall;
   assign w_b_eff      = bus.sub ? ~bus.b : bus.b;

   always_comb begin
      w_in[0]                  = '0;
      w_in[0].valid            = bus.in_valid;
      w_in[0].carry            = bus.sub;
      w_in[0].sub              = bus.sub;
      w_in[0].a[WIDTH-1:0]     = bus.a;
      w_in[0].b[WIDTH-1:0]     = w_b_eff;
`ifdef ADDSUB_SAT_EN
      w_in[0].sat              = bus.sat;
`endif
      for (int k = 1; k < LAT; k++) begin
         w_in[k] = r_stage[k-1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_stage
         cla_slice16 u_slice (
            .a        (w_in[gi].a[gi*SLICE_W +: SLICE_W]),
            .b        (w_in[gi].b[gi*SLICE_W +: SLICE_W]),
            .cin      (w_in[gi].carry),
            .s        (w_s[gi]),
            .cout     (w_co[gi]),
            .c_msb_in (w_cm[gi])
         );
      end
   endgenerate

   always_comb begin
      for (int k = 0; k < LAT; k++) begin
         w_out[k]                             = w_in[k];
         w_out[k].psum[k*SLICE_W +: SLICE_W]  = w_s[k];
         w_out[k].carry                       = w_co[k];
         w_out[k].c_msb                       = w_cm[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            r_stage[k] <= '0;
         end
      end else if (!w_stall) begin
         for (int k = 0; k < LAT; k++) begin
            r_stage[k] <= w_out[k];
         end
      end
   end

   assign w_raw = r_stage[LAT-1].psum[WIDTH-1:0];
   assign w_ovf = r_stage[LAT-1].carry ^ r_stage[LAT-1].c_msb;

`ifdef ADDSUB_SAT_EN
   logic w_sign_a;
   assign w_sign_a = r_stage[LAT-1].a[WIDTH-1];
   assign w_sum    = (r_stage[LAT-1].sat & w_ovf) ? {w_sign_a, {(WIDTH-1){~w_sign_a}}} : w_raw;
`else
   assign w_sum    = w_raw;
`endif

   assign bus.out_valid = r_stage[LAT-1].valid;
   assign bus.sum       = w_sum;
   assign bus.cout      = r_stage[LAT-1].carry;
   assign bus.ovf       = w_ovf;
   assign bus.zero      = r_stage[LAT-1].valid & ~|w_sum;
endmodule
